// File: rtl/score_keeper_pkg.sv
// Shared types and limits for the tug-of-war match scorer.
package score_pkg;

   typedef enum logic {PLAY, OVER} match_state_t;

   localparam int MAX_PLAYERS = 8;

endpackage

// File: rtl/score_keeper_player_score.sv
// Saturating round-win counter for one player. It clears on clr and stops at WIN_SCORE.
module player_score #(
   parameter int SW        = 3,
   parameter int WIN_SCORE = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          inc,
   output logic          at_target,
   output logic [SW-1:0] score
);

   logic [SW-1:0] score_q, score_d;

   assign at_target = (score_q == SW'(WIN_SCORE));

   always_comb begin
      score_d = score_q;
      if (clr) begin
         score_d = '0;
      end else if (inc && !at_target) begin
         score_d = score_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;

endmodule

// File: rtl/score_keeper.sv
// Multi-player match scorer: counts rising win edges, latches match-over with winner/tie,
// and reports a combinational leader from the registered scores.
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int WIN_SCORE   = 7,
   parameter int SW          = $clog2(WIN_SCORE + 1),
   parameter int PW          = $clog2(NUM_PLAYERS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_PLAYERS-1:0]    win,
   input  logic                      new_game,
   output logic [NUM_PLAYERS*SW-1:0] score,
   output logic                      game_over,
   output logic [PW-1:0]             winner,
   output logic                      tie,
   output logic [PW-1:0]             leader,
   output logic                      lead_valid
);

   localparam logic [SW-1:0] LAST_STEP = SW'(WIN_SCORE - 1);

   match_state_t           state_q;
   logic [NUM_PLAYERS-1:0] win_q, rise, inc, hit, at_tgt;
   logic                   game_over_q, tie_q, multi_hit, shared;
   logic [PW-1:0]          winner_q, first_hit, lead;
   logic [SW-1:0]          sc [NUM_PLAYERS];
   logic [SW-1:0]          max_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q <= '0;
      end else begin
         win_q <= win;
      end
   end

   // new_game wins over any rise on the same edge; that rise is simply lost.
   assign rise = win & ~win_q;
   assign inc  = (state_q == PLAY && !new_game) ? rise : '0;

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
      player_score #(
         .SW        (SW),
         .WIN_SCORE (WIN_SCORE)
      ) u_player_score (
         .clk       (clk),
         .reset_n   (reset_n),
         .clr       (new_game),
         .inc       (inc[i]),
         .at_target (at_tgt[i]),
         .score     (sc[i])
      );
      assign score[i*SW +: SW] = sc[i];
      assign hit[i] = inc[i] & ~at_tgt[i] & (sc[i] == LAST_STEP);
   end

   always_comb begin
      first_hit = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (hit[i]) first_hit = PW'(i);
      end
      multi_hit = ($countones(hit) > 1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= PLAY;
         game_over_q <= 1'b0;
         winner_q    <= '0;
         tie_q       <= 1'b0;
      end else if (new_game) begin
         state_q     <= PLAY;
         game_over_q <= 1'b0;
         winner_q    <= '0;
         tie_q       <= 1'b0;
      end else if (state_q == PLAY && |hit) begin
         state_q     <= OVER;
         game_over_q <= 1'b1;
         winner_q    <= first_hit;
         tie_q       <= multi_hit;
      end
   end

   // Strict '>' keeps the lowest index on equal scores; any equal max marks the lead shared.
   always_comb begin
      max_v  = sc[0];
      lead   = '0;
      shared = 1'b0;
      for (int i = 1; i < NUM_PLAYERS; i++) begin
         if (sc[i] > max_v) begin
            max_v  = sc[i];
            lead   = PW'(i);
            shared = 1'b0;
         end else if (sc[i] == max_v) begin
            shared = 1'b1;
         end
      end
   end

   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign tie        = tie_q;
   assign leader     = lead;
   assign lead_valid = ~shared;

endmodule
